// File: rtl/time_set_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_pkg
//  Description : Shared types, field widths and range limits for the
//                time-setting controller. Also provides clamp/wrap helpers
//                for the hours and minutes edit fields.
//  Revision    : 1.0  initial release
// ============================================================================
package time_set_pkg;

    localparam int HOURS_W     = 5;
    localparam int MINUTES_W   = 6;
    localparam int HOURS_MAX   = 24;
    localparam int MINUTES_MAX = 60;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SET_H  = 2'd1,
        ST_SET_M  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    // Out-of-range live values are replaced by zero on capture so the
    // editor always starts from a legal time.
    function automatic logic [HOURS_W-1:0] clamp_hours(input logic [HOURS_W-1:0] v);
        return (v >= HOURS_W'(HOURS_MAX)) ? '0 : v;
    endfunction

    function automatic logic [MINUTES_W-1:0] clamp_minutes(input logic [MINUTES_W-1:0] v);
        return (v >= MINUTES_W'(MINUTES_MAX)) ? '0 : v;
    endfunction

    function automatic logic [HOURS_W-1:0] wrap_inc_hours(input logic [HOURS_W-1:0] v);
        return (v == HOURS_W'(HOURS_MAX - 1)) ? '0 : v + HOURS_W'(1);
    endfunction

    function automatic logic [MINUTES_W-1:0] wrap_inc_minutes(input logic [MINUTES_W-1:0] v);
        return (v == MINUTES_W'(MINUTES_MAX - 1)) ? '0 : v + MINUTES_W'(1);
    endfunction

endpackage : time_set_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, counting debouncer and press-edge
//                pulse generator for one raw push button.
//  Ports       : clk, rst   - clock / synchronous active-high reset
//                i_btn      - raw asynchronous button, high = pressed
//                o_press    - one-cycle pulse on a debounced 0->1 edge
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_fill;
    logic               r_armed;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // r_fill marks when r_sync2 carries a real post-reset sample.
            r_fill  <= {r_fill[0], 1'b1};
            // A press is only honoured once the button has been seen
            // released, so a button held through reset never fires.
            if (r_fill[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2 & r_armed;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl
//  Description : Two-button time-setting controller. A mode press captures
//                the live time into shadow registers, steps through hours
//                and minutes editing, then strobes load to write the edited
//                time back. Edits are abandoned after an idle timeout.
//  Ports       : clk, rst                 - clock / sync active-high reset
//                btn_mode, btn_inc        - raw buttons, high = pressed
//                hours_in, minutes_in     - live time from the counters
//                load                     - one-cycle load strobe
//                hours_out, minutes_out   - edited time (valid with load)
//                hold                     - freeze seconds while editing
//                disp_hours, disp_minutes - value to display
//                blank_mask               - {hours,minutes} blink blanking
//                mode                     - current state encoding
//  Revision    : 1.0  initial release
// ============================================================================
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_BITS      = 6,
    parameter int TIMEOUT_BITS    = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_mode,
    input  logic                 btn_inc,
    input  logic [HOURS_W-1:0]   hours_in,
    input  logic [MINUTES_W-1:0] minutes_in,
    output logic                 load,
    output logic [HOURS_W-1:0]   hours_out,
    output logic [MINUTES_W-1:0] minutes_out,
    output logic                 hold,
    output logic [HOURS_W-1:0]   disp_hours,
    output logic [MINUTES_W-1:0] disp_minutes,
    output logic [10:0]          blank_mask,
    output logic [1:0]           mode
);

    localparam logic [1:0] c_RUN    = ST_RUN;
    localparam logic [1:0] c_SET_H  = ST_SET_H;
    localparam logic [1:0] c_SET_M  = ST_SET_M;
    localparam logic [1:0] c_COMMIT = ST_COMMIT;
    localparam logic [TIMEOUT_BITS-1:0] c_IDLE_LAST = '1;

    logic                    w_press_mode;
    logic                    w_press_inc;
    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [HOURS_W-1:0]      r_shadow_h;
    logic [HOURS_W-1:0]      w_shadow_h_nxt;
    logic [MINUTES_W-1:0]    r_shadow_m;
    logic [MINUTES_W-1:0]    w_shadow_m_nxt;
    logic [BLINK_BITS-1:0]   r_blink;
    logic [TIMEOUT_BITS-1:0] r_idle;
    logic                    w_editing;
    logic                    w_timeout;
    logic                    w_phase;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_mode),
        .o_press (w_press_mode)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_inc),
        .o_press (w_press_inc)
    );

    assign w_editing = (r_state == c_SET_H) || (r_state == c_SET_M);
    assign w_timeout = (r_idle == c_IDLE_LAST);

    // Mode has priority over inc, and any press beats the timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_shadow_h_nxt = r_shadow_h;
        w_shadow_m_nxt = r_shadow_m;
        case (r_state)
            c_RUN: begin
                if (w_press_mode) begin
                    w_shadow_h_nxt = clamp_hours(hours_in);
                    w_shadow_m_nxt = clamp_minutes(minutes_in);
                    w_state_nxt    = c_SET_H;
                end
            end
            c_SET_H: begin
                if (w_press_mode) begin
                    w_state_nxt = c_SET_M;
                end else if (w_press_inc) begin
                    w_shadow_h_nxt = wrap_inc_hours(r_shadow_h);
                end else if (w_timeout) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_SET_M: begin
                if (w_press_mode) begin
                    w_state_nxt = c_COMMIT;
                end else if (w_press_inc) begin
                    w_shadow_m_nxt = wrap_inc_minutes(r_shadow_m);
                end else if (w_timeout) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_COMMIT: begin
                w_state_nxt = c_RUN;
            end
            default: begin
                w_state_nxt = c_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_RUN;
            r_shadow_h <= '0;
            r_shadow_m <= '0;
            r_blink    <= '0;
            r_idle     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow_h <= w_shadow_h_nxt;
            r_shadow_m <= w_shadow_m_nxt;
            r_blink    <= r_blink + BLINK_BITS'(1);
            if (w_press_mode || w_press_inc || (w_state_nxt != r_state)) begin
                r_idle <= '0;
            end else if (w_editing) begin
                r_idle <= r_idle + TIMEOUT_BITS'(1);
            end
        end
    end

    assign w_phase      = r_blink[BLINK_BITS-1];
    assign load         = (r_state == c_COMMIT);
    assign hold         = (r_state != c_RUN);
    assign hours_out    = r_shadow_h;
    assign minutes_out  = r_shadow_m;
    assign disp_hours   = (r_state == c_RUN) ? hours_in   : r_shadow_h;
    assign disp_minutes = (r_state == c_RUN) ? minutes_in : r_shadow_m;
    assign blank_mask   = {{HOURS_W{(r_state == c_SET_H) && w_phase}},
                           {MINUTES_W{(r_state == c_SET_M) && w_phase}}};
    assign mode         = r_state;

endmodule : time_set_ctrl
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set_ctrl
//  Description : Self-checking bench for time_set_ctrl. A cycle-level
//                behavioural model built from the button/edit rules predicts
//                every output after each clock edge; directed scenarios add
//                explicit end-to-end checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_time_set_ctrl;

    localparam int DEB = 4;
    localparam int BB  = 6;
    localparam int TB  = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [4:0]  hours_in = 5'd9;
    logic [5:0]  minutes_in = 6'd30;
    logic        load;
    logic [4:0]  hours_out;
    logic [5:0]  minutes_out;
    logic        hold;
    logic [4:0]  disp_hours;
    logic [5:0]  disp_minutes;
    logic [10:0] blank_mask;
    logic [1:0]  mode;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_BITS      (BB),
        .TIMEOUT_BITS    (TB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .hours_in     (hours_in),
        .minutes_in   (minutes_in),
        .load         (load),
        .hours_out    (hours_out),
        .minutes_out  (minutes_out),
        .hold         (hold),
        .disp_hours   (disp_hours),
        .disp_minutes (disp_minutes),
        .blank_mask   (blank_mask),
        .mode         (mode)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Load monitor
    int ld_cnt = 0;
    int ld_h   = 0;
    int ld_m   = 0;

    // Reference model state: edge count since reset, edit state/shadows,
    // edge of last activity, press events waiting for the next edge.
    int m_n, m_st, m_sh, m_sm, m_last;
    bit m_pm, m_pi;
    bit m_deb [2];
    bit m_arm [2];
    bit m_hist [2][64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Synchronized level seen by the debouncer at edge m: raw from two edges
    // earlier, zero while the synchronizer still holds reset values.
    function automatic bit yval(input int b, input int m);
        if (m < 3) return 1'b0;
        return m_hist[b][(m - 2) % 64];
    endfunction

    task automatic model_edge();
        int nxt;
        bit ev [2];
        bit rawv [2];
        bit all_new;
        if (rst) begin
            m_n = 0; m_st = 0; m_sh = 0; m_sm = 0; m_last = 0;
            m_pm = 0; m_pi = 0;
            for (int b = 0; b < 2; b++) begin
                m_deb[b] = 0;
                m_arm[b] = 0;
            end
            return;
        end
        m_n++;
        nxt = m_st;
        case (m_st)
            0: if (m_pm) begin
                   m_sh = (int'(hours_in) > 23) ? 0 : int'(hours_in);
                   m_sm = (int'(minutes_in) > 59) ? 0 : int'(minutes_in);
                   nxt = 1;
               end
            1: if (m_pm) nxt = 2;
               else if (m_pi) m_sh = (m_sh + 1) % 24;
               else if (m_n - m_last == (1 << TB)) nxt = 0;
            2: if (m_pm) nxt = 3;
               else if (m_pi) m_sm = (m_sm + 1) % 60;
               else if (m_n - m_last == (1 << TB)) nxt = 0;
            default: nxt = 0;
        endcase
        if (m_pm || m_pi || nxt != m_st) m_last = m_n;
        m_st = nxt;

        rawv[0] = btn_mode;
        rawv[1] = btn_inc;
        for (int b = 0; b < 2; b++) begin
            m_hist[b][m_n % 64] = rawv[b];
            all_new = 1;
            for (int j = 0; j < DEB; j++)
                if (yval(b, m_n - j) == m_deb[b]) all_new = 0;
            ev[b] = 0;
            if (all_new) begin
                m_deb[b] = !m_deb[b];
                ev[b] = m_deb[b] && m_arm[b];
            end
            if (m_n >= 3 && yval(b, m_n) == 1'b0) m_arm[b] = 1;
        end
        m_pm = ev[0];
        m_pi = ev[1];
    endtask

    task automatic check_all();
        bit ph;
        int exp_blank;
        ph = ((m_n % (1 << BB)) >= (1 << (BB - 1)));
        exp_blank = (m_st == 1 && ph) ? 'h7C0 : (m_st == 2 && ph) ? 'h03F : 0;
        check("mode",     32'(mode),         32'(m_st));
        check("load",     32'(load),         32'(m_st == 3));
        check("hold",     32'(hold),         32'(m_st != 0));
        check("hours_out",32'(hours_out),    32'(m_sh));
        check("min_out",  32'(minutes_out),  32'(m_sm));
        check("disp_h",   32'(disp_hours),   (m_st == 0) ? 32'(hours_in) : 32'(m_sh));
        check("disp_m",   32'(disp_minutes), (m_st == 0) ? 32'(minutes_in) : 32'(m_sm));
        check("blank",    32'(blank_mask),   32'(exp_blank));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (load === 1'b1) begin
            ld_cnt++;
            ld_h = int'(hours_out);
            ld_m = int'(minutes_out);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
    endtask

    task automatic press(input bit pm, input bit pi, input int hl, input int rl);
        btn_mode = pm;
        btn_inc  = pi;
        repeat (hl) tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (rl) tick();
    endtask

    initial begin
        int k;
        int sel;

        // Reset state
        rst = 1'b1;
        tick();
        check("rst_mode",  32'(mode), 0);
        check("rst_load",  32'(load), 0);
        check("rst_hold",  32'(hold), 0);
        check("rst_blank", 32'(blank_mask), 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Enter SET_H from 09:30
        hours_in = 5'd9; minutes_in = 6'd30;
        press(1, 0, 8, 8);
        check("enter_mode", 32'(mode), 1);
        check("enter_hold", 32'(hold), 1);
        check("enter_disp", 32'(disp_hours), 9);

        // Full edit sequence -> 11:31
        ld_cnt = 0;
        press(0, 1, 8, 8);
        press(0, 1, 8, 8);
        press(1, 0, 8, 8);
        press(0, 1, 8, 8);
        press(1, 0, 8, 8);
        check("seq_loads", 32'(ld_cnt), 1);
        check("seq_h",     32'(ld_h), 11);
        check("seq_m",     32'(ld_m), 31);
        check("seq_mode",  32'(mode), 0);
        check("seq_hold",  32'(hold), 0);

        // Wrap at 23 and 59
        hours_in = 5'd23; minutes_in = 6'd59;
        do_reset();
        press(1, 0, 8, 8);
        check("wrap_h_pre", 32'(hours_out), 23);
        press(0, 1, 8, 8);
        check("wrap_h", 32'(hours_out), 0);
        press(1, 0, 8, 8);
        check("wrap_m_pre", 32'(minutes_out), 59);
        press(0, 1, 8, 8);
        check("wrap_m", 32'(minutes_out), 0);

        // Simultaneous mode+inc in SET_H
        hours_in = 5'd5; minutes_in = 6'd10;
        do_reset();
        press(1, 0, 8, 8);
        press(1, 1, 8, 8);
        check("both_mode", 32'(mode), 2);
        check("both_h",    32'(hours_out), 5);

        // Chatter on mode, ending stable high
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_mode = (i % 2 == 1);
            if (i < 9) tick();
        end
        k = 0;
        while (mode !== 2'd1 && k < 50) begin
            tick();
            k++;
        end
        check("chatter_lat", 32'(k), 32'(DEB + 3));
        repeat (20) tick();
        check("chatter_once", 32'(mode), 1);
        btn_mode = 1'b0;
        repeat (8) tick();

        // Button held through reset never fires
        btn_mode = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        check("held_rst", 32'(mode), 0);
        btn_mode = 1'b0;
        repeat (8) tick();
        press(1, 0, 8, 8);
        check("after_held", 32'(mode), 1);

        // Timeout from SET_M
        btn_mode = 1'b1;
        k = 0;
        while (mode !== 2'd2 && k < 50) begin
            tick();
            k++;
        end
        check("to_enter", 32'(mode), 2);
        btn_mode = 1'b0;
        ld_cnt = 0;
        k = 0;
        while (mode !== 2'd0 && k < 5000) begin
            tick();
            k++;
        end
        check("to_cycles", 32'(k), 32'(1 << TB));
        check("to_noload", 32'(ld_cnt), 0);

        // Reset mid-SET_H
        repeat (8) tick();
        press(1, 0, 8, 8);
        check("mid_pre", 32'(mode), 1);
        ld_cnt = 0;
        rst = 1'b1;
        tick();
        check("mid_mode", 32'(mode), 0);
        check("mid_hold", 32'(hold), 0);
        check("mid_load", 32'(ld_cnt), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            hours_in   = 5'($urandom_range(0, 31));
            minutes_in = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            sel = $urandom_range(0, 3);
            btn_mode = sel[0];
            btn_inc  = sel[1];
            repeat ($urandom_range(1, 12)) tick();
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            repeat ($urandom_range(1, 12)) tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_time_set_ctrl
`default_nettype wire

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a button level.
REQ-002 Parameter BLINK_BITS, default 6: blink counter width; blink period is 2^BLINK_BITS cycles.
REQ-003 Parameter TIMEOUT_BITS, default 12: edit-idle counter width; timeout after 2^TIMEOUT_BITS cycles.
REQ-004 clk  in  1  single clock; every flop is clocked on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 btn_mode  in  1  raw, asynchronous mode button, high = pressed.
REQ-007 btn_inc  in  1  raw, asynchronous increment button, high = pressed.
REQ-008 hours_in  in  5  live hours from the clock counters, 0..23.
REQ-009 minutes_in  in  6  live minutes from the clock counters, 0..59.
REQ-010 load  out  1  one-cycle strobe telling the counters to load hours_out/minutes_out.
REQ-011 hours_out  out  5  edited hours value to load.
REQ-012 minutes_out  out  6  edited minutes value to load.
REQ-013 hold  out  1  high while editing; the counters freeze the seconds count.
REQ-014 disp_hours  out  5  hours value to show on the display.
REQ-015 disp_minutes  out  6  minutes value to show on the display.
REQ-016 blank_mask  out  11  {hours[4:0], minutes[5:0]} pixel blank mask, 1 = pixel forced off.
REQ-017 mode  out  2  current FSM state encoding.

Function
REQ-018 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronized value.
REQ-019 A press event SHALL be a one-cycle pulse on the debounced level's 0->1 edge; holding a button SHALL NOT repeat the event.
REQ-020 FSM states SHALL be RUN=0, SET_H=1, SET_M=2, COMMIT=3, and mode SHALL equal the state.
REQ-021 RUN: a mode press SHALL capture hours_in/minutes_in into shadow registers and move to SET_H; inc presses SHALL be ignored.
REQ-022 Capture clamp: a captured hours_in >23 SHALL store 0, and a captured minutes_in >59 SHALL store 0.
REQ-023 SET_H: an inc press SHALL set shadow_h to (shadow_h==23 ? 0 : shadow_h+1); a mode press SHALL move to SET_M.
REQ-024 SET_M: an inc press SHALL set shadow_m to (shadow_m==59 ? 0 : shadow_m+1); a mode press SHALL move to COMMIT.
REQ-025 COMMIT: load SHALL be 1 for exactly this one cycle, with hours_out/minutes_out equal to the shadows; the next state SHALL be RUN.
REQ-026 A mode press and an inc press in the same cycle: mode SHALL win and inc SHALL be discarded.
REQ-027 hold SHALL be 1 in SET_H, SET_M and COMMIT, and 0 in RUN.
REQ-028 hours_out/minutes_out SHALL always reflect the shadow registers; they are meaningful only while load=1.
REQ-029 disp_hours/disp_minutes SHALL be hours_in/minutes_in in RUN and the shadows in every other state (combinational mux).
REQ-030 A free-running BLINK_BITS counter SHALL run in all states; its MSB is the blink phase.
REQ-031 blank_mask[10:6] SHALL be all ones in SET_H when phase=1; blank_mask[5:0] SHALL be all ones in SET_M when phase=1; blank_mask SHALL be 0 otherwise.
REQ-032 The idle counter SHALL clear on any press event or state change and SHALL increment in SET_H/SET_M.
REQ-033 When the idle counter reaches 2^TIMEOUT_BITS-1, the FSM SHALL return to RUN with no load strobe, discarding the edits.

Reset
REQ-034 While rst=1 at a clock edge: state=RUN, shadows=0, load=0, hold=0, synchronizer/debouncer state=released, blink and idle counters=0.
REQ-035 rst asserted mid-edit SHALL abandon the edit with no load pulse; outputs SHALL reach reset values on the first edge with rst=1.
REQ-036 The first press event after reset SHALL require a 0->1 debounced edge; a button held through reset SHALL NOT generate an event.

Structure
REQ-037 Package time_set_pkg SHALL hold the state enum, HOURS_MAX=24, MINUTES_MAX=60 and the field widths 5 and 6.
REQ-038 Sub-module btn_debounce (synchronizer + debouncer + edge pulse) SHALL be instantiated once per button.

Verification
REQ-039 Reset, hours_in=9, minutes_in=30, mode press -> state SET_H after debounce latency, hold=1, disp_hours=9.
REQ-040 In SET_H with shadow_h=23, one inc press -> shadow_h=0; with shadow_m=59 in SET_M, one inc press -> shadow_m=0.
REQ-041 Full sequence mode, inc x2, mode, inc, mode from 09:30 -> exactly one load pulse with hours_out=11, minutes_out=31; then RUN, hold=0.
REQ-042 Button chatter (toggle every cycle for 10 cycles, then stable high) -> exactly one press event, DEBOUNCE_CYCLES+2 cycles after the last toggle.
REQ-043 Enter SET_M, then no presses for 2^TIMEOUT_BITS cycles -> return to RUN, load never asserted; rst mid-SET_H -> RUN next cycle, no load.
REQ-044 Simultaneous mode+inc presses in SET_H -> state SET_M, shadow_h unchanged.
